// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants and shared types for the
// character-scan timing generator.
package vga_timing_pkg;

   localparam int unsigned H_ACTIVE_DEF   = 640;
   localparam int unsigned H_FP_DEF       = 16;
   localparam int unsigned H_SYNC_DEF     = 96;
   localparam int unsigned H_BP_DEF       = 48;
   localparam int unsigned V_ACTIVE_DEF   = 480;
   localparam int unsigned V_FP_DEF       = 10;
   localparam int unsigned V_SYNC_DEF     = 2;
   localparam int unsigned V_BP_DEF       = 33;
   localparam logic        SYNC_ACTIVE_DEF = 1'b0;
   localparam int unsigned PIPE_DELAY_DEF = 2;

   localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam int unsigned COORD_W    = 10;
   localparam int unsigned CHAR_SHIFT = 3;
   localparam int unsigned CHAR_W     = COORD_W - CHAR_SHIFT;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic blank;
   } sync_t;

   // Half-open window test lo <= val < hi on a raster counter.
   function automatic logic in_range(coord_t val, int unsigned lo, int unsigned hi);
      return (32'(val) >= lo) && (32'(val) < hi);
   endfunction

endpackage

// File: rtl/char_scan_timing_if.sv
// Coordinate and video-timing bundle from the scan generator to the
// character display.
interface char_scan_timing_if;
   import vga_timing_pkg::*;

   logic [CHAR_W-1:0]     char_column;
   logic [CHAR_W-1:0]     char_line;
   logic [CHAR_SHIFT-1:0] subchar_pixel;
   logic [CHAR_SHIFT-1:0] subchar_line;
   logic                  blank;
   logic                  hsync;
   logic                  vsync;
   logic                  frame_start;

   modport master (
      output char_column, char_line, subchar_pixel, subchar_line,
      output blank, hsync, vsync, frame_start
   );

   modport slave (
      input char_column, char_line, subchar_pixel, subchar_line,
      input blank, hsync, vsync, frame_start
   );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset to a
// programmable value; depth 0 is a plain wire.
module sync_delay_line #(
   parameter int unsigned       DEPTH   = 2,
   parameter int unsigned       WIDTH   = 3,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign q_o = d_i;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage_q [DEPTH];

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
            end else begin
               stage_q[0] <= d_i;
               for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign q_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/char_scan_timing.sv
// Raster counter producing character-cell scan coordinates plus hsync/vsync/
// blank delayed to match the character generator's read latency.
module char_scan_timing
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
   parameter int unsigned H_FP        = H_FP_DEF,
   parameter int unsigned H_SYNC      = H_SYNC_DEF,
   parameter int unsigned H_BP        = H_BP_DEF,
   parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
   parameter int unsigned V_FP        = V_FP_DEF,
   parameter int unsigned V_SYNC      = V_SYNC_DEF,
   parameter int unsigned V_BP        = V_BP_DEF,
   parameter logic        SYNC_ACTIVE = SYNC_ACTIVE_DEF,
   parameter int unsigned PIPE_DELAY  = PIPE_DELAY_DEF
) (
   input  logic                pixel_clock,
   input  logic                reset,
   char_scan_timing_if.master  scan
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;
   localparam coord_t      H_LAST   = coord_t'(H_TOTAL - 1);
   localparam coord_t      V_LAST   = coord_t'(V_TOTAL - 1);

   coord_t                h_q, h_d;
   coord_t                v_q, v_d;
   logic                  h_wrap;
   logic                  active_d, active_raw;
   logic                  frame_q, frame_d;
   logic [CHAR_W-1:0]     col_q, col_d;
   logic [CHAR_W-1:0]     line_q, line_d;
   logic [CHAR_SHIFT-1:0] spix_q, spix_d;
   logic [CHAR_SHIFT-1:0] sline_q, sline_d;
   sync_t                 raw_s, dly_s;

   // Coordinates are registered from the next counter value so they line up
   // with h_q/v_q in the same cycle.
   always_comb begin
      h_wrap   = (h_q == H_LAST);
      h_d      = h_wrap ? '0 : h_q + 1'b1;
      v_d      = v_q;
      if (h_wrap) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      frame_d  = h_wrap && (v_q == V_LAST);
      active_d = in_range(h_d, 0, H_ACTIVE) && in_range(v_d, 0, V_ACTIVE);
      col_d    = '0;
      line_d   = '0;
      spix_d   = '0;
      sline_d  = '0;
      if (active_d) begin
         col_d   = h_d[COORD_W-1:CHAR_SHIFT];
         spix_d  = h_d[CHAR_SHIFT-1:0];
         line_d  = v_d[COORD_W-1:CHAR_SHIFT];
         sline_d = v_d[CHAR_SHIFT-1:0];
      end
   end

   always_comb begin
      active_raw  = in_range(h_q, 0, H_ACTIVE) && in_range(v_q, 0, V_ACTIVE);
      raw_s.hsync = in_range(h_q, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      raw_s.vsync = in_range(v_q, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      raw_s.blank = ~active_raw;
   end

   always_ff @(posedge pixel_clock or negedge reset) begin
      if (!reset) begin
         h_q     <= '0;
         v_q     <= '0;
         frame_q <= 1'b0;
         col_q   <= '0;
         line_q  <= '0;
         spix_q  <= '0;
         sline_q <= '0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         frame_q <= frame_d;
         col_q   <= col_d;
         line_q  <= line_d;
         spix_q  <= spix_d;
         sline_q <= sline_d;
      end
   end

   sync_delay_line #(
      .DEPTH   (PIPE_DELAY),
      .WIDTH   (3),
      .RST_VAL ({~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b1})
   ) u_delay (
      .clk_i  (pixel_clock),
      .rst_ni (reset),
      .d_i    (raw_s),
      .q_o    (dly_s)
   );

   assign scan.char_column   = col_q;
   assign scan.char_line     = line_q;
   assign scan.subchar_pixel = spix_q;
   assign scan.subchar_line  = sline_q;
   assign scan.frame_start   = frame_q;
   assign scan.hsync         = dly_s.hsync;
   assign scan.vsync         = dly_s.vsync;
   assign scan.blank         = dly_s.blank;

endmodule

// File: tb/tb_char_scan_timing.sv
// Scoreboard bench: default-timing, small-timing (active-high sync, depth 3)
// and zero-delay instances checked every cycle against a reference raster model.
module tb_char_scan_timing;
   import vga_timing_pkg::*;

   localparam int NI = 3;
   localparam int   HA [NI] = '{H_ACTIVE_DEF, 16, 16};
   localparam int   HF [NI] = '{H_FP_DEF, 2, 2};
   localparam int   HS [NI] = '{H_SYNC_DEF, 4, 4};
   localparam int   HB [NI] = '{H_BP_DEF, 2, 2};
   localparam int   VA [NI] = '{V_ACTIVE_DEF, 16, 16};
   localparam int   VF [NI] = '{V_FP_DEF, 1, 1};
   localparam int   VS [NI] = '{V_SYNC_DEF, 2, 2};
   localparam int   VB [NI] = '{V_BP_DEF, 1, 1};
   localparam logic SA [NI] = '{1'b0, 1'b1, 1'b0};
   localparam int   PD [NI] = '{2, 3, 0};

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   char_scan_timing_if if0 ();
   char_scan_timing_if if1 ();
   char_scan_timing_if if2 ();

   char_scan_timing u_dut (.pixel_clock(clk), .reset(rst_n), .scan(if0.master));

   char_scan_timing #(
      .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
      .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
      .SYNC_ACTIVE(SA[1]), .PIPE_DELAY(PD[1])
   ) u_small (.pixel_clock(clk), .reset(rst_n), .scan(if1.master));

   char_scan_timing #(
      .H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HS[2]), .H_BP(HB[2]),
      .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VS[2]), .V_BP(VB[2]),
      .SYNC_ACTIVE(SA[2]), .PIPE_DELAY(PD[2])
   ) u_zero (.pixel_clock(clk), .reset(rst_n), .scan(if2.master));

   logic [23:0] obs [NI];
   assign obs[0] = {if0.char_column, if0.char_line, if0.subchar_pixel, if0.subchar_line,
                    if0.blank, if0.hsync, if0.vsync, if0.frame_start};
   assign obs[1] = {if1.char_column, if1.char_line, if1.subchar_pixel, if1.subchar_line,
                    if1.blank, if1.hsync, if1.vsync, if1.frame_start};
   assign obs[2] = {if2.char_column, if2.char_line, if2.subchar_pixel, if2.subchar_line,
                    if2.blank, if2.hsync, if2.vsync, if2.frame_start};

   int         mh [NI];
   int         mv [NI];
   logic       mfs [NI];
   logic [2:0] sq [NI][$];
   int         n_tests = 0;
   int         n_fail = 0;
   int         idx;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] raw_lvl(input int i);
      logic hs, vs, act;
      hs  = (mh[i] >= HA[i] + HF[i]) && (mh[i] < HA[i] + HF[i] + HS[i]);
      vs  = (mv[i] >= VA[i] + VF[i]) && (mv[i] < VA[i] + VF[i] + VS[i]);
      act = (mh[i] < HA[i]) && (mv[i] < VA[i]);
      return {hs ? SA[i] : ~SA[i], vs ? SA[i] : ~SA[i], ~act};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         mh[i] = 0;
         mv[i] = 0;
         mfs[i] = 1'b0;
         sq[i].delete();
         repeat (PD[i]) sq[i].push_back({~SA[i], ~SA[i], 1'b1});
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < NI; i++) begin
         int ht, vt;
         ht = HA[i] + HF[i] + HS[i] + HB[i];
         vt = VA[i] + VF[i] + VS[i] + VB[i];
         mfs[i] = (mh[i] == ht - 1) && (mv[i] == vt - 1);
         if (mh[i] == ht - 1) begin
            mh[i] = 0;
            mv[i] = (mv[i] == vt - 1) ? 0 : mv[i] + 1;
         end else begin
            mh[i] = mh[i] + 1;
         end
      end
   endtask

   // Raw sync/blank enter the queue now and leave PD cycles later.
   task automatic observe();
      for (int i = 0; i < NI; i++) begin
         logic [2:0] e;
         logic       act;
         sq[i].push_back(raw_lvl(i));
         e   = sq[i].pop_front();
         act = (mh[i] < HA[i]) && (mv[i] < VA[i]);
         chk($sformatf("i%0d.col", i),   32'(obs[i][23:17]), act ? 32'(mh[i] / 8) : 0);
         chk($sformatf("i%0d.line", i),  32'(obs[i][16:10]), act ? 32'(mv[i] / 8) : 0);
         chk($sformatf("i%0d.spix", i),  32'(obs[i][9:7]),   act ? 32'(mh[i] % 8) : 0);
         chk($sformatf("i%0d.sline", i), 32'(obs[i][6:4]),   act ? 32'(mv[i] % 8) : 0);
         chk($sformatf("i%0d.blank", i), 32'(obs[i][3]), 32'(e[0]));
         chk($sformatf("i%0d.hsync", i), 32'(obs[i][2]), 32'(e[2]));
         chk($sformatf("i%0d.vsync", i), 32'(obs[i][1]), 32'(e[1]));
         chk($sformatf("i%0d.fs", i),    32'(obs[i][0]), 32'(mfs[i]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (!rst_n) model_reset();
      else model_step();
      observe();
   endtask

   initial begin
      int hs_cnt, hs_first, hs_fall1, vs_cnt, vs_first, fs1_cnt, fs0_cnt, fs_first, guard;
      logic hs_prev;
      hs_cnt = 0; hs_first = -1; hs_fall1 = -1; vs_cnt = 0; vs_first = -1;
      fs1_cnt = 0; fs0_cnt = 0; fs_first = -1; hs_prev = 1'b1;

      rst_n = 1'b0;
      model_reset();
      repeat (5) tick();
      chk("rst_hsync", 32'(if0.hsync), 1);
      chk("rst_vsync", 32'(if0.vsync), 1);
      chk("rst_blank", 32'(if0.blank), 1);
      chk("rst_fs", 32'(if0.frame_start), 0);

      rst_n = 1'b1;
      idx = 0;
      repeat (16000) begin
         tick();
         idx++;
         if (idx == 1) chk("blank_d1", 32'(if0.blank), 1);
         if (idx == 2) chk("blank_d2", 32'(if0.blank), 0);
         if (idx == 1) chk("pd0_blank", 32'(if2.blank), 0);
         if (idx == 17) chk("pd0_hs_off", 32'(if2.hsync), 1);
         if (idx == 18) chk("pd0_hs_on", 32'(if2.hsync), 0);
         if (mh[0] == 13 && mv[0] == 0) begin
            chk("col13", 32'(if0.char_column), 1);
            chk("spix13", 32'(if0.subchar_pixel), 5);
         end
         if (mh[0] == 0 && mv[0] == 17) begin
            chk("line17", 32'(if0.char_line), 2);
            chk("sline17", 32'(if0.subchar_line), 1);
         end
         if (mh[0] == 640 && mv[0] == 3) chk("col640", 32'(if0.char_column), 0);
         if (mh[0] == 641 && mv[0] == 3) chk("blank641", 32'(if0.blank), 0);
         if (mh[0] == 642 && mv[0] == 3) chk("blank642", 32'(if0.blank), 1);
         if (idx <= 800 && if0.hsync == 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = idx;
         end
         if (idx > 800 && hs_prev && !if0.hsync && hs_fall1 < 0) hs_fall1 = idx;
         hs_prev = if0.hsync;
         if (idx <= 480 && if1.vsync == 1'b1) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = idx;
         end
         if (if1.frame_start) fs1_cnt++;
         if (if0.frame_start) fs0_cnt++;
      end
      chk("hs_width", 32'(hs_cnt), 96);
      chk("hs_start", 32'(hs_first), 658);
      chk("line_period", 32'(hs_fall1 - hs_first), 800);
      chk("vs_width", 32'(vs_cnt), 48);
      chk("vs_start", 32'(vs_first), 411);
      chk("fs_small_cnt", 32'(fs1_cnt), 33);
      chk("fs_dflt_cnt", 32'(fs0_cnt), 0);

      guard = 0;
      while (mh[0] != 300 && guard < 2000) begin
         tick();
         guard++;
      end
      chk("reach_h300", 32'(mh[0]), 300);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      observe();
      chk("arst_col", 32'(if0.char_column), 0);
      chk("arst_hsync", 32'(if0.hsync), 1);
      chk("arst_blank", 32'(if0.blank), 1);
      repeat (3) tick();

      rst_n = 1'b1;
      idx = 0;
      fs1_cnt = 0;
      repeat (1000) begin
         tick();
         idx++;
         if (if1.frame_start) begin
            fs1_cnt++;
            if (fs_first < 0) fs_first = idx;
         end
      end
      chk("fs_after_rst_cnt", 32'(fs1_cnt), 2);
      chk("fs_after_rst_first", 32'(fs_first), 480);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
